// File: rtl/fire_pkg.sv
// Shared types and helpers for the fire-layer expand sequencer.
// Holds the scheduler state encoding and the derived address-width function.
package fire_pkg;

    typedef enum logic [2:0] {IDLE, RUN, HOLD, DRAIN, DONE} sched_state_t;

    // Width of an address into n entries, never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fire_sched_dly.sv
// Fixed-depth delay line for {valid, pixel index} between the MAC enable and the ofm write.
// A pixel field only moves with its valid bit, so the output index holds the last written pixel.
module fire_sched_dly #(
    parameter int DEPTH = 2,
    parameter int PW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [PW-1:0] in_pix,
    output logic          out_valid,
    output logic [PW-1:0] out_pix
);

    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    pix [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pix[i] <= '0;
            end
        end else begin
            vld[0] <= in_valid;
            if (in_valid) begin
                pix[0] <= in_pix;
            end
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) begin
                    pix[i] <= pix[i-1];
                end
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_pix   = pix[DEPTH-1];

endmodule

// File: rtl/fire_expand_sched.sv
// Sequencer for one fire-layer expand MAC array: walks pixels x input channels,
// issues ifm/weight addresses, MAC enable/clear and the per-pixel ofm write.
module fire_expand_sched
    import fire_pkg::*;
#(
    parameter int WOUT    = 13,
    parameter int CHIN    = 64,
    parameter int MAC_LAT = 2,
    localparam int NPIX   = WOUT * WOUT,
    localparam int AW_IFM = addr_w(NPIX * CHIN),
    localparam int AW_OFM = addr_w(NPIX),
    localparam int AW_W   = addr_w(CHIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              ofm_ready,
    output logic              busy,
    output logic [AW_IFM-1:0] ifm_addr,
    output logic [AW_W-1:0]   w_addr,
    output logic              mac_en,
    output logic              mac_clr,
    output logic              ofm_we,
    output logic [AW_OFM-1:0] ofm_addr,
    output logic              done
);

    sched_state_t state, state_nxt;
    logic issue;

    // Counters name the next (pix, ch) to issue; base tracks pix*CHIN.
    logic [AW_W-1:0]   ch_n;
    logic [AW_OFM-1:0] pix_n;
    logic [AW_IFM-1:0] base;
    logic first_ch, last_ch, last_item;

    logic              iss_q, clr_q, last_q;
    logic [AW_OFM-1:0] pix_q;
    logic              last_s1;
    logic [AW_OFM-1:0] pix_s1;

    assign first_ch  = (ch_n == '0);
    assign last_ch   = (ch_n == AW_W'(CHIN - 1));
    assign last_item = last_ch && (pix_n == AW_OFM'(NPIX - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new pixel is only started when the output buffer can take it.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (ofm_ready) begin
                        issue     = 1'b1;
                        state_nxt = last_item ? DRAIN : RUN;
                    end else begin
                        state_nxt = HOLD;
                    end
                end
            end
            RUN: begin
                busy = 1'b1;
                if (first_ch && !ofm_ready) begin
                    state_nxt = HOLD;
                end else begin
                    issue = 1'b1;
                    if (last_item) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (ofm_ready) begin
                    issue     = 1'b1;
                    state_nxt = last_item ? DRAIN : RUN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (ofm_we && (ofm_addr == AW_OFM'(NPIX - 1))) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ch_n     <= '0;
            pix_n    <= '0;
            base     <= '0;
            ifm_addr <= '0;
            w_addr   <= '0;
            iss_q    <= 1'b0;
            clr_q    <= 1'b0;
            last_q   <= 1'b0;
            pix_q    <= '0;
            mac_en   <= 1'b0;
            mac_clr  <= 1'b0;
            last_s1  <= 1'b0;
            pix_s1   <= '0;
        end else begin
            iss_q <= issue;
            if (issue) begin
                ifm_addr <= base + AW_IFM'(ch_n);
                w_addr   <= ch_n;
                clr_q    <= first_ch;
                last_q   <= last_ch;
                pix_q    <= pix_n;
                if (last_ch) begin
                    ch_n  <= '0;
                    pix_n <= pix_n + 1'b1;
                    base  <= base + AW_IFM'(CHIN);
                end else begin
                    ch_n <= ch_n + 1'b1;
                end
            end else if (state == DONE) begin
                ch_n  <= '0;
                pix_n <= '0;
                base  <= '0;
            end
            // Stage 1 lines up with the RAM/ROM read data.
            mac_en  <= iss_q;
            mac_clr <= iss_q & clr_q;
            last_s1 <= iss_q & last_q;
            pix_s1  <= pix_q;
        end
    end

    fire_sched_dly #(
        .DEPTH (MAC_LAT),
        .PW    (AW_OFM)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (last_s1),
        .in_pix    (pix_s1),
        .out_valid (ofm_we),
        .out_pix   (ofm_addr)
    );

endmodule

// File: tb/tb_fire_expand_sched.sv
// Self-checking bench for fire_expand_sched: directed timing runs plus
// randomised ofm_ready runs against an item-index reference model.
module tb_fire_expand_sched;
    import fire_pkg::*;

    localparam int LAT    = 2;
    localparam int B_C    = 5;
    localparam int B_NPIX = 9;
    localparam int B_TOT  = 45;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic start_a = 1'b0, ready_a = 1'b1;
    logic busy_a, en_a, clr_a, we_a, done_a;
    logic [3:0] ifm_a;
    logic [1:0] w_a, oa_a;

    logic start_b = 1'b0, ready_b = 1'b1;
    logic busy_b, en_b, clr_b, we_b, done_b;
    logic [5:0] ifm_b;
    logic [2:0] w_b;
    logic [3:0] oa_b;

    logic start_c = 1'b0, ready_c = 1'b1;
    logic busy_c, en_c, clr_c, we_c, done_c;
    logic [1:0] ifm_c, oa_c;
    logic [0:0] w_c;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fire_expand_sched #(.WOUT(2), .CHIN(4), .MAC_LAT(LAT)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .ofm_ready(ready_a), .busy(busy_a),
        .ifm_addr(ifm_a), .w_addr(w_a), .mac_en(en_a), .mac_clr(clr_a),
        .ofm_we(we_a), .ofm_addr(oa_a), .done(done_a));

    fire_expand_sched #(.WOUT(3), .CHIN(B_C), .MAC_LAT(LAT)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .ofm_ready(ready_b), .busy(busy_b),
        .ifm_addr(ifm_b), .w_addr(w_b), .mac_en(en_b), .mac_clr(clr_b),
        .ofm_we(we_b), .ofm_addr(oa_b), .done(done_b));

    fire_expand_sched #(.WOUT(2), .CHIN(1), .MAC_LAT(LAT)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .ofm_ready(ready_c), .busy(busy_c),
        .ifm_addr(ifm_c), .w_addr(w_c), .mac_en(en_c), .mac_clr(clr_c),
        .ofm_we(we_c), .ofm_addr(oa_c), .done(done_c));

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done_a(input string tag);
        int seen = 0;
        for (int i = 0; i < 80 && seen == 0; i++) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        checkOutput(tag, seen, 1);
    endtask

    // Reference model for instance B: flat item index k = pix*CHIN + ch,
    // events scheduled into a small ring of future cycles.
    int m_phase = 0;
    int m_k = 0;
    int cyc = 0;
    bit m_busy = 1'b0;
    int e_issue[8], e_iaddr[8], e_en[8], e_clr[8], e_we[8], e_wpix[8], e_done[8];
    int exp_ifm = 0, exp_oaddr = 0;
    int prev_ifm = 0;
    int en_cnt[B_NPIX], clr_cnt[B_NPIX];
    int wr_next = 0;

    task automatic cycle_b(input bit st, input bit rdy);
        int s;
        @(negedge clk);
        s = cyc % 8;
        if (e_issue[s] != 0) exp_ifm = e_iaddr[s];
        if (e_we[s] != 0) exp_oaddr = e_wpix[s];
        if (e_done[s] != 0) begin
            m_busy  = 1'b0;
            m_phase = 3;
        end
        checkOutput("b_ifm_addr", ifm_b, exp_ifm);
        checkOutput("b_w_addr", w_b, exp_ifm % B_C);
        checkOutput("b_mac_en", en_b, e_en[s]);
        checkOutput("b_mac_clr", clr_b, e_en[s] & e_clr[s]);
        checkOutput("b_ofm_we", we_b, e_we[s]);
        checkOutput("b_ofm_addr", oa_b, exp_oaddr);
        checkOutput("b_done", done_b, e_done[s]);
        checkOutput("b_busy", busy_b, m_busy);
        if (en_b && prev_ifm < B_TOT) begin
            en_cnt[prev_ifm / B_C]++;
            if (clr_b) begin
                clr_cnt[prev_ifm / B_C]++;
                checkOutput("b_clr_first_ch", prev_ifm % B_C, 0);
            end
        end
        if (we_b) begin
            checkOutput("b_write_order", oa_b, wr_next);
            wr_next++;
        end
        prev_ifm = int'(ifm_b);
        e_issue[s] = 0; e_en[s] = 0; e_clr[s] = 0; e_we[s] = 0; e_done[s] = 0;

        start_b = st;
        ready_b = rdy;
        if (m_phase == 3) begin
            m_phase = 0;
        end else begin
            if (m_phase == 0 && st) begin
                m_phase = 1;
                m_k     = 0;
                m_busy  = 1'b1;
            end
            if (m_phase == 1 && ((m_k % B_C) != 0 || rdy)) begin
                e_issue[(cyc + 1) % 8] = 1;
                e_iaddr[(cyc + 1) % 8] = m_k;
                e_en[(cyc + 2) % 8]    = 1;
                e_clr[(cyc + 2) % 8]   = ((m_k % B_C) == 0) ? 1 : 0;
                if ((m_k % B_C) == B_C - 1) begin
                    e_we[(cyc + 2 + LAT) % 8]   = 1;
                    e_wpix[(cyc + 2 + LAT) % 8] = m_k / B_C;
                    if (m_k == B_TOT - 1) e_done[(cyc + 3 + LAT) % 8] = 1;
                end
                m_k++;
                if (m_k == B_TOT) m_phase = 2;
            end
        end
        cyc++;
    endtask

    initial begin
        int dn, nwe, ndn, td, n;

        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_ifm", ifm_a, 0);
        checkOutput("rst_w", w_a, 0);
        checkOutput("rst_en", en_a, 0);
        checkOutput("rst_clr", clr_a, 0);
        checkOutput("rst_we", we_a, 0);
        checkOutput("rst_oaddr", oa_a, 0);
        checkOutput("rst_done", done_a, 0);
        rst = 1'b0;

        // Plain run, no stalls.
        @(negedge clk);
        start_a = 1'b1;
        for (int t = 1; t <= 24; t++) begin
            @(negedge clk);
            if (t == 1) start_a = 1'b0;
            checkOutput("t1_ifm", ifm_a, (t <= 16) ? t - 1 : 15);
            checkOutput("t1_w", w_a, (t <= 16) ? (t - 1) % 4 : 3);
            checkOutput("t1_en", en_a, (t >= 2 && t <= 17));
            checkOutput("t1_clr", clr_a, (t >= 2 && t <= 14 && (t - 2) % 4 == 0));
            checkOutput("t1_we", we_a, (t >= 7 && t <= 19 && (t - 7) % 4 == 0));
            checkOutput("t1_oaddr", oa_a, (t < 7) ? 0 : ((t >= 19) ? 3 : (t - 7) / 4));
            checkOutput("t1_done", done_a, (t == 20));
            checkOutput("t1_busy", busy_a, (t <= 19));
        end

        // Output buffer not ready at pixel 1's boundary for three cycles.
        @(negedge clk);
        start_a = 1'b1;
        dn = 0;
        for (int t = 1; t <= 30; t++) begin
            @(negedge clk);
            if (t == 1) start_a = 1'b0;
            if (t >= 4 && t <= 7) checkOutput("t2_ifm_frozen", ifm_a, 3);
            if (t >= 6 && t <= 8) checkOutput("t2_en_gap", en_a, 0);
            if (t == 8) checkOutput("t2_ifm_resume", ifm_a, 4);
            if (t == 9) checkOutput("t2_clr_resume", clr_a, 1);
            if (t == 7) begin
                checkOutput("t2_we_pix0", we_a, 1);
                checkOutput("t2_oaddr_pix0", oa_a, 0);
            end
            if (done_a) dn++;
            ready_a = !(t >= 4 && t <= 6);
        end
        checkOutput("t2_done_count", dn, 1);
        checkOutput("t2_idle", busy_a, 0);

        // Reset in the middle of a run.
        @(negedge clk);
        start_a = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            @(negedge clk);
            if (t == 1) start_a = 1'b0;
            if (t == 7) begin
                checkOutput("t4_ifm_pre", ifm_a, 6);
                rst = 1'b1;
            end
            if (t == 8) begin
                rst = 1'b0;
                checkOutput("t4_ifm", ifm_a, 0);
                checkOutput("t4_w", w_a, 0);
                checkOutput("t4_en", en_a, 0);
                checkOutput("t4_clr", clr_a, 0);
                checkOutput("t4_we", we_a, 0);
                checkOutput("t4_oaddr", oa_a, 0);
                checkOutput("t4_done", done_a, 0);
                checkOutput("t4_busy", busy_a, 0);
            end
        end
        nwe = 0;
        ndn = 0;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            if (we_a) nwe++;
            if (done_a) ndn++;
        end
        checkOutput("t4_no_we_after", nwe, 0);
        checkOutput("t4_no_done_after", ndn, 0);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        checkOutput("t4_restart_ifm0", ifm_a, 0);
        checkOutput("t4_restart_busy", busy_a, 1);
        @(negedge clk);
        checkOutput("t4_restart_ifm1", ifm_a, 1);
        wait_done_a("t4_restart_done");

        // Start while running and in the DONE cycle is ignored; the next cycle accepts it.
        @(negedge clk);
        start_a = 1'b1;
        td = -1;
        for (int t = 1; t <= 40 && td < 0; t++) begin
            @(negedge clk);
            start_a = (t == 5);
            if (done_a) td = t;
        end
        checkOutput("t5_done_time", td, 20);
        start_a = 1'b1;
        @(negedge clk);
        checkOutput("t5_after_done_busy", busy_a, 0);
        checkOutput("t5_after_done_done", done_a, 0);
        @(negedge clk);
        start_a = 1'b0;
        checkOutput("t5_rerun_busy", busy_a, 1);
        checkOutput("t5_rerun_ifm", ifm_a, 0);
        wait_done_a("t5_rerun_done");

        // Single input channel: every enable also clears, writes back-to-back.
        @(negedge clk);
        start_c = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            @(negedge clk);
            if (t == 1) start_c = 1'b0;
            checkOutput("t3_ifm", ifm_c, (t <= 4) ? t - 1 : 3);
            checkOutput("t3_en", en_c, (t >= 2 && t <= 5));
            checkOutput("t3_clr", clr_c, (t >= 2 && t <= 5));
            checkOutput("t3_we", we_c, (t >= 4 && t <= 7));
            if (we_c) checkOutput("t3_oaddr", oa_c, t - 4);
            checkOutput("t3_done", done_c, (t == 8));
        end

        // Randomised ofm_ready and stray start pulses.
        for (int run = 0; run < 20; run++) begin
            for (int p = 0; p < B_NPIX; p++) begin
                en_cnt[p]  = 0;
                clr_cnt[p] = 0;
            end
            wr_next = 0;
            cycle_b(1'b1, 1'($urandom_range(0, 1)));
            n = 0;
            while (m_phase != 0 && n < 600) begin
                cycle_b($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
                n++;
            end
            checkOutput("b_run_bound", m_phase, 0);
            for (int p = 0; p < B_NPIX; p++) begin
                checkOutput("b_mac_count", en_cnt[p], B_C);
                checkOutput("b_clr_count", clr_cnt[p], 1);
            end
            checkOutput("b_write_count", wr_next, B_NPIX);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
